// File: rtl/battle_sequencer.sv
//------------------------------------------------------------------------------
// battle_sequencer
// Page/turn sequencer for a bullet-hell battle: menu, dodge turns with a
// cycle timer, action menu (fight/item/flee), attack resolution, win/lose.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module battle_sequencer #(
    parameter int HP_W         = 8,
    parameter int MON_HP_MAX   = 100,
    parameter int HEAL_AMT     = 10,
    parameter int DODGE_CYCLES = 1000,
    parameter int ITEM_CNT     = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      key,
    input  logic            isDeath,
    input  logic            atkPass,
    input  logic [HP_W-1:0] dmgMon,
    input  logic            isDmgComplete,
    input  logic [7:0]      damage,
    input  logic            heal,
    output logic [7:0]      state,
    output logic [15:0]     playerInstruction,
    output logic            instrValid,
    output logic            isMove,
    output logic            startDmg,
    output logic [HP_W-1:0] monHP,
    output logic [7:0]      turnCount,
    output logic [3:0]      itemsLeft
);

    typedef enum logic [3:0] {
        PG_MENU   = 4'h1,
        PG_WIN    = 4'h2,
        PG_LOSE   = 4'h3,
        PG_DODGE  = 4'h9,
        PG_ATTACK = 4'hA,
        PG_ACTION = 4'hB
    } page_t;

    localparam int          TMR_W     = (DODGE_CYCLES > 2) ? $clog2(DODGE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(DODGE_CYCLES - 1);
    localparam logic [7:0]  C_HEAL    = 8'(HEAL_AMT);
    localparam logic [3:0]  C_ITEMS   = 4'(ITEM_CNT);
    localparam logic [HP_W:0] C_WIN_HP = (HP_W+1)'(MON_HP_MAX);

    localparam logic [3:0]  OP_HPY    = 4'd1;
    localparam logic [3:0]  OP_DPY    = 4'd2;
    localparam logic [3:0]  OP_MOV    = 4'd5;

    localparam logic [3:0]  K_W       = 4'd1;
    localparam logic [3:0]  K_A       = 4'd2;
    localparam logic [3:0]  K_D       = 4'd4;
    localparam logic [3:0]  K_J       = 4'd5;
    localparam logic [3:0]  K_SPACE   = 4'd8;

    localparam logic [1:0]  CUR_FIGHT = 2'd0;
    localparam logic [1:0]  CUR_ITEM  = 2'd1;
    localparam logic [1:0]  CUR_FLEE  = 2'd2;

    page_t            page_q,   page_d;
    logic [1:0]       cursor_q, cursor_d;
    logic [TMR_W-1:0] timer_q,  timer_d;
    logic [7:0]       turn_q,   turn_d;
    logic [3:0]       items_q,  items_d;
    logic [HP_W-1:0]  monhp_q,  monhp_d;
    logic [15:0]      instr_q,  instr_d;
    logic             valid_q,  valid_d;
    logic             move_q,   move_d;
    logic             sdmg_q,   sdmg_d;

    // Monster damage sum carries one extra bit so overflow can be saturated.
    logic [HP_W:0]    w_sum;
    logic [1:0]       w_dir;
    logic             w_is_move_key;

    assign w_sum         = {1'b0, monhp_q} + {1'b0, dmgMon};
    assign w_dir         = 2'(key - 4'd1);
    assign w_is_move_key = (key >= K_W) && (key <= K_D);

    // Next-state and next-output decisions for every page.
    always_comb begin
        page_d   = page_q;
        cursor_d = cursor_q;
        timer_d  = timer_q;
        turn_d   = turn_q;
        items_d  = items_q;
        monhp_d  = monhp_q;
        instr_d  = instr_q;
        valid_d  = 1'b0;
        move_d   = 1'b0;
        sdmg_d   = 1'b0;

        case (page_q)
            PG_MENU: begin
                if (key == K_SPACE) begin
                    page_d  = PG_DODGE;
                    monhp_d = '0;
                    turn_d  = '0;
                    timer_d = '0;
                    items_d = C_ITEMS;
                end
            end

            PG_DODGE: begin
                if (isDeath) begin
                    page_d = PG_LOSE;
                end else if (isDmgComplete) begin
                    instr_d = heal ? {OP_HPY, C_HEAL, 4'h0} : {OP_DPY, damage, 4'h0};
                    sdmg_d  = 1'b1;
                    valid_d = 1'b1;
                    // A pending expiry waits at the last count for a free cycle.
                    if (timer_q != C_TMR_LAST) begin
                        timer_d = timer_q + 1'b1;
                    end
                end else if (timer_q == C_TMR_LAST) begin
                    page_d   = PG_ACTION;
                    cursor_d = CUR_FIGHT;
                    timer_d  = '0;
                    turn_d   = (turn_q == 8'hFF) ? turn_q : turn_q + 8'd1;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (w_is_move_key) begin
                        instr_d = {OP_MOV, 6'b0, w_dir, 4'h0};
                        move_d  = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        instr_d = '0;
                    end
                end
            end

            PG_ACTION: begin
                if (key == K_A) begin
                    cursor_d = (cursor_q == CUR_FIGHT) ? CUR_FLEE : cursor_q - 2'd1;
                end else if (key == K_D) begin
                    cursor_d = (cursor_q == CUR_FLEE) ? CUR_FIGHT : cursor_q + 2'd1;
                end else if (key == K_J) begin
                    if (cursor_q == CUR_FIGHT) begin
                        page_d   = PG_ATTACK;
                        cursor_d = '0;
                    end else if (cursor_q == CUR_ITEM) begin
                        if (items_q != 4'd0) begin
                            instr_d  = {OP_HPY, C_HEAL, 4'h0};
                            sdmg_d   = 1'b1;
                            valid_d  = 1'b1;
                            items_d  = items_q - 4'd1;
                            page_d   = PG_DODGE;
                            cursor_d = '0;
                            timer_d  = '0;
                        end
                    end else begin
                        page_d   = PG_MENU;
                        cursor_d = '0;
                    end
                end
            end

            PG_ATTACK: begin
                if (atkPass) begin
                    monhp_d = w_sum[HP_W] ? {HP_W{1'b1}} : w_sum[HP_W-1:0];
                    if (w_sum >= C_WIN_HP) begin
                        page_d = PG_WIN;
                    end else begin
                        page_d  = PG_DODGE;
                        timer_d = '0;
                    end
                end
            end

            PG_WIN, PG_LOSE: begin
                if (key == K_SPACE) begin
                    page_d = PG_MENU;
                end
            end

            default: begin
                page_d   = PG_MENU;
                cursor_d = '0;
            end
        endcase
    end

    // State and output registers; reset overrides the cycle's decisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            page_q   <= PG_MENU;
            cursor_q <= '0;
            timer_q  <= '0;
            turn_q   <= '0;
            items_q  <= C_ITEMS;
            monhp_q  <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            move_q   <= 1'b0;
            sdmg_q   <= 1'b0;
        end else begin
            page_q   <= page_d;
            cursor_q <= cursor_d;
            timer_q  <= timer_d;
            turn_q   <= turn_d;
            items_q  <= items_d;
            monhp_q  <= monhp_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            move_q   <= move_d;
            sdmg_q   <= sdmg_d;
        end
    end

    // Cursor is cleared on every exit from ACTION, so it reads as 0 elsewhere.
    assign state             = {page_q, 2'b00, cursor_q};
    assign playerInstruction = instr_q;
    assign instrValid        = valid_q;
    assign isMove            = move_q;
    assign startDmg          = sdmg_q;
    assign monHP             = monhp_q;
    assign turnCount         = turn_q;
    assign itemsLeft         = items_q;

endmodule

`default_nettype wire

// File: tb/tb_battle_sequencer.sv
//------------------------------------------------------------------------------
// tb_battle_sequencer
// Directed scenarios followed by random play, checked against a page-level
// behavioural model of the battle rules.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_battle_sequencer;

    localparam int DC    = 4;
    localparam int ITEMS = 3;
    localparam int HEAL  = 10;
    localparam int WINHP = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  key = '0;
    logic        isDeath = 1'b0;
    logic        atkPass = 1'b0;
    logic [7:0]  dmgMon = '0;
    logic        isDmgComplete = 1'b0;
    logic [7:0]  damage = '0;
    logic        heal = 1'b0;
    logic [7:0]  state;
    logic [15:0] playerInstruction;
    logic        instrValid;
    logic        isMove;
    logic        startDmg;
    logic [7:0]  monHP;
    logic [7:0]  turnCount;
    logic [3:0]  itemsLeft;

    int checks = 0;
    int errors = 0;

    // Model of the game: page number, menu cursor, timer, counters, outputs.
    int m_page, m_cur, m_tmr, m_turn, m_items, m_hp, m_instr, m_valid, m_move, m_sd;

    battle_sequencer #(
        .HP_W(8), .MON_HP_MAX(WINHP), .HEAL_AMT(HEAL),
        .DODGE_CYCLES(DC), .ITEM_CNT(ITEMS)
    ) dut (
        .clk(clk), .rst(rst), .key(key), .isDeath(isDeath), .atkPass(atkPass),
        .dmgMon(dmgMon), .isDmgComplete(isDmgComplete), .damage(damage), .heal(heal),
        .state(state), .playerInstruction(playerInstruction), .instrValid(instrValid),
        .isMove(isMove), .startDmg(startDmg), .monHP(monHP), .turnCount(turnCount),
        .itemsLeft(itemsLeft)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply the battle rules to the model for one clock with the given inputs.
    task automatic model_step(input logic r, input int k, input logic d, input logic ap,
                              input int dm, input logic dc, input int dg, input logic hl);
        int s;
        if (r) begin
            m_page = 1; m_cur = 0; m_tmr = 0; m_turn = 0; m_items = ITEMS;
            m_hp = 0; m_instr = 0; m_valid = 0; m_move = 0; m_sd = 0;
            return;
        end
        m_valid = 0; m_move = 0; m_sd = 0;
        if (m_page == 1) begin
            if (k == 8) begin
                m_page = 9; m_hp = 0; m_turn = 0; m_tmr = 0; m_items = ITEMS;
            end
        end else if (m_page == 9) begin
            if (d) begin
                m_page = 3;
            end else if (dc) begin
                m_instr = hl ? (1 * 4096 + HEAL * 16) : (2 * 4096 + dg * 16);
                m_sd = 1; m_valid = 1;
                if (m_tmr < DC - 1) m_tmr++;
            end else if (m_tmr == DC - 1) begin
                m_page = 11; m_cur = 0; m_tmr = 0;
                if (m_turn < 255) m_turn++;
            end else begin
                m_tmr++;
                if (k >= 1 && k <= 4) begin
                    m_instr = 5 * 4096 + (k - 1) * 16;
                    m_move = 1; m_valid = 1;
                end else begin
                    m_instr = 0;
                end
            end
        end else if (m_page == 11) begin
            if (k == 2) m_cur = (m_cur + 2) % 3;
            else if (k == 4) m_cur = (m_cur + 1) % 3;
            else if (k == 5) begin
                if (m_cur == 0) m_page = 10;
                else if (m_cur == 1) begin
                    if (m_items > 0) begin
                        m_instr = 1 * 4096 + HEAL * 16;
                        m_sd = 1; m_valid = 1; m_items--;
                        m_page = 9; m_tmr = 0;
                    end
                end else m_page = 1;
            end
        end else if (m_page == 10) begin
            if (ap) begin
                s = m_hp + dm;
                m_hp = (s > 255) ? 255 : s;
                if (s >= WINHP) m_page = 2;
                else begin
                    m_page = 9; m_tmr = 0;
                end
            end
        end else if (m_page == 2 || m_page == 3) begin
            if (k == 8) m_page = 1;
        end else begin
            m_page = 1;
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare all outputs.
    task automatic step(input logic r, input int k, input logic d, input logic ap,
                        input int dm, input logic dc, input int dg, input logic hl);
        int exp_state;
        rst = r; key = 4'(k); isDeath = d; atkPass = ap; dmgMon = 8'(dm);
        isDmgComplete = dc; damage = 8'(dg); heal = hl;
        model_step(r, k, d, ap, dm, dc, dg, hl);
        @(posedge clk);
        #1;
        exp_state = m_page * 16 + ((m_page == 11) ? m_cur : 0);
        chk("state",     16'(state),        16'(exp_state));
        chk("instr",     playerInstruction, 16'(m_instr));
        chk("instrValid",16'(instrValid),   16'(m_valid));
        chk("isMove",    16'(isMove),       16'(m_move));
        chk("startDmg",  16'(startDmg),     16'(m_sd));
        chk("monHP",     16'(monHP),        16'(m_hp));
        chk("turnCount", 16'(turnCount),    16'(m_turn));
        chk("itemsLeft", 16'(itemsLeft),    16'(m_items));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic press(input int k);
        step(0, k, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic attack(input int dm);
        step(0, 0, 0, 1, dm, 0, 0, 0);
    endtask

    initial begin
        // Reset and start a battle.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 8, 0, 0, 0, 1, 0, 0);
        chk("reset_state", 16'(state), 16'h0010);
        chk("reset_items", 16'(itemsLeft), 16'd3);
        press(8);
        chk("start_state", 16'(state), 16'h0090);

        // Movement, damage hit, strobe length, then turn expiry.
        press(4);
        chk("move_D", playerInstruction, 16'h5030);
        step(0, 0, 0, 0, 0, 1, 7, 0);
        chk("dpy_7", playerInstruction, 16'h2070);
        chk("strobe_on", 16'(startDmg), 16'd1);
        idle(1);
        chk("strobe_off", 16'(startDmg), 16'd0);
        idle(1);
        chk("expiry_state", 16'(state), 16'h00B0);
        chk("expiry_turn", 16'(turnCount), 16'd1);

        // Cursor walk with wrap both ways.
        press(4); press(4); press(4);
        chk("cursor_wrap_up", 16'(state), 16'h00B0);
        press(2);
        chk("cursor_wrap_dn", 16'(state), 16'h00B2);

        // Use all heal items, then one more attempt.
        press(2);
        press(5);
        chk("item_hpy", playerInstruction, 16'h10A0);
        for (int i = 0; i < 3; i++) begin
            idle(DC);
            press(4);
            press(5);
        end
        chk("no_items_state", 16'(state), 16'h00B1);
        chk("no_items_left", 16'(itemsLeft), 16'd0);

        // Flee back to the menu.
        press(4); press(5);
        chk("flee_state", 16'(state), 16'h0010);

        // Attack to exactly the winning total.
        press(8); idle(DC); press(5); attack(95);
        idle(DC); press(5); attack(5);
        chk("win_hp", 16'(monHP), 16'd100);
        chk("win_state", 16'(state), 16'h0020);
        press(8);

        // Saturating damage sum.
        press(8); idle(DC); press(5); attack(95);
        idle(DC); press(5); attack(200);
        chk("sat_hp", 16'(monHP), 16'd255);
        press(8);

        // Death has priority over a simultaneous hit.
        press(8);
        step(0, 0, 1, 0, 0, 1, 9, 0);
        chk("death_state", 16'(state), 16'h0030);
        chk("death_strobe", 16'(startDmg), 16'd0);
        press(8);

        // Reset in the middle of DODGE and ATTACK discards that cycle.
        press(8);
        step(1, 4, 0, 0, 0, 1, 5, 0);
        press(8); idle(DC); press(5);
        step(1, 0, 0, 1, 200, 0, 0, 0);

        // Random play.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 int'($urandom_range(0, 8)),
                 ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, 60)),
                 ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
